// File: rtl/mvdm_out_pkg.sv
// Shared constants and types for the MVDM serial result output stage.
// Build option SAD_SERIAL_PARITY_EN appends an even-parity bit to every frame.
package mvdm_out_pkg;

  localparam int unsigned DATA_W = 28;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned SAD_W  = 24;

`ifdef SAD_SERIAL_PARITY_EN
  localparam int unsigned FRAME_LEN = DATA_W + 1;
`else
  localparam int unsigned FRAME_LEN = DATA_W;
`endif

  typedef enum logic {
    IDLE,
    SHIFT
  } ser_state_t;

endpackage

// File: rtl/sad_fifo.sv
// Synchronous result-word FIFO; full/empty derived from extended-pointer compare.
module sad_fifo #(
  parameter int unsigned DATA_W = 28,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wptr;
  logic [AW:0]       rptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/sad_serializer.sv
// MVDM output stage: buffers result words and streams them LSB first on out_sad.
// Build option SAD_SERIAL_PARITY_EN adds a trailing even-parity bit per frame.
module sad_serializer #(
  parameter int unsigned DATA_W = mvdm_out_pkg::DATA_W,
  parameter int unsigned DEPTH  = mvdm_out_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              res_ready,
  output logic              out_valid,
  output logic              out_sad
);

  import mvdm_out_pkg::*;

`ifdef SAD_SERIAL_PARITY_EN
  localparam int unsigned FRAME_BITS = DATA_W + 1;
`else
  localparam int unsigned FRAME_BITS = DATA_W;
`endif
  localparam int unsigned CW = $clog2(FRAME_BITS + 1);

  ser_state_t            state, state_n;
  logic [CW-1:0]         bit_cnt, bit_cnt_n;
  logic [FRAME_BITS-1:0] shreg, shreg_n;
  logic [FRAME_BITS-1:0] frame_word;
  logic [DATA_W-1:0]     head;
  logic                  out_valid_n, out_sad_n;
  logic                  push, pop, load, full, empty;

  // Ready depends only on registered FIFO state so there is no path from pop.
  assign res_ready = !rst && !full;
  assign push      = res_valid && res_ready;

  sad_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (res_data),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

`ifdef SAD_SERIAL_PARITY_EN
  assign frame_word = {^head, head};
`else
  assign frame_word = head;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      out_valid <= 1'b0;
      out_sad   <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      out_valid <= out_valid_n;
      out_sad   <= out_sad_n;
    end
  end

  // shreg holds the not-yet-emitted bits, so bit 0 always feeds the next edge.
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shreg_n     = shreg;
    out_valid_n = out_valid;
    out_sad_n   = out_sad;
    load        = 1'b0;

    unique case (state)
      IDLE: begin
        if (!empty) load = 1'b1;
      end
      SHIFT: begin
        if (bit_cnt == CW'(FRAME_BITS)) begin
          if (!empty) begin
            load = 1'b1;
          end else begin
            state_n     = IDLE;
            out_valid_n = 1'b0;
            out_sad_n   = 1'b0;
            bit_cnt_n   = '0;
          end
        end else begin
          out_sad_n = shreg[0];
          shreg_n   = shreg >> 1;
          bit_cnt_n = bit_cnt + CW'(1);
        end
      end
    endcase

    if (load) begin
      state_n     = SHIFT;
      out_valid_n = 1'b1;
      out_sad_n   = frame_word[0];
      shreg_n     = frame_word >> 1;
      bit_cnt_n   = CW'(1);
    end
  end

  assign pop = load;

endmodule

// File: tb/tb_sad_serializer.sv
// Self-checking bench for sad_serializer: scoreboard of accepted words versus
// frames reassembled from the serial output, plus timing corner sequences.
module tb_sad_serializer;

  localparam int unsigned DW = 28;
`ifdef SAD_SERIAL_PARITY_EN
  localparam int unsigned FL = DW + 1;
`else
  localparam int unsigned FL = DW;
`endif

  logic          clk;
  logic          rst;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic          res_ready;
  logic          out_valid;
  logic          out_sad;

  int            checks = 0;
  int            errors = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_word;
  logic [31:0]   bits;
  int unsigned   cnt = 0;
  int unsigned   frames = 0;
  logic [DW-1:0] last_word = '0;
  logic          last_par = 1'b0;
  bit            mon_en = 1'b0;

  typedef struct {
    logic [DW-1:0] data;
    logic          par;
  } vec_t;

  vec_t tbl[6];

  sad_serializer #(
    .DATA_W (DW),
    .DEPTH  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_ready (res_ready),
    .out_valid (out_valid),
    .out_sad   (out_sad)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d, output int unsigned waits);
    waits     = 0;
    res_valid = 1'b1;
    res_data  = d;
    while (!res_ready && waits < 500) begin
      tick();
      waits++;
    end
    if (!res_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got ready=0 expected ready=1 for %0h", d);
    end
    tick();
    res_valid = 1'b0;
    res_data  = DW'($urandom);
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 3000) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    tick();
  endtask

  task automatic measure_run(input string name, input int unsigned exp_len);
    int unsigned n = 0;
    int unsigned run = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    while (out_valid && run < 1000) begin
      run++;
      tick();
    end
    chk(name, run, exp_len);
  endtask

  // Scoreboard: words are expected in acceptance order; reset discards them.
  always @(posedge clk) begin
    if (rst) exp_q.delete();
    else if (res_valid && res_ready) exp_q.push_back(res_data);
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst) begin
        cnt = 0;
      end else if (out_valid) begin
        bits[cnt] = out_sad;
        cnt++;
        if (cnt == FL) begin
          cnt       = 0;
          frames++;
          last_word = bits[DW-1:0];
`ifdef SAD_SERIAL_PARITY_EN
          last_par  = bits[DW];
`endif
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_unexpected: got %0h expected no frame", bits[DW-1:0]);
          end else begin
            exp_word = exp_q.pop_front();
            chk("frame_data", {4'h0, bits[DW-1:0]}, {4'h0, exp_word});
`ifdef SAD_SERIAL_PARITY_EN
            chk("frame_parity", bits[DW], ^exp_word);
`endif
          end
        end
      end else begin
        chk("idle_sad_zero", out_sad, 0);
        if (cnt != 0) begin
          chk("frame_truncated", cnt, 0);
          cnt = 0;
        end
      end
    end
  end

  initial begin
    int unsigned w, f0, n, run;

    tbl[0] = '{28'h0000000, 1'b0};
    tbl[1] = '{28'hFFFFFFF, 1'b0};
    tbl[2] = '{28'h8000000, 1'b1};
    tbl[3] = '{28'h0000001, 1'b1};
    tbl[4] = '{28'hAAAAAAA, 1'b0};
    tbl[5] = '{28'h0000007, 1'b1};

    rst       = 1'b1;
    res_valid = 1'b0;
    res_data  = '0;

    repeat (3) begin
      tick();
      chk("ready_in_reset", res_ready, 0);
    end
    chk("reset_valid", out_valid, 0);
    chk("reset_sad", out_sad, 0);
    mon_en = 1'b1;
    rst    = 1'b0;
    #1;
    chk("ready_after_reset", res_ready, 1);

    // Single word: latency and frame length.
    push(28'hA000135, w);
    chk("lat_e0_valid", out_valid, 0);
    tick();
    chk("lat_e1_valid", out_valid, 1);
    chk("lat_bit0", out_sad, 1);
    run = 1;
    n   = 0;
    while (n < 200) begin
      tick();
      n++;
      if (!out_valid) break;
      run++;
    end
    chk("single_len", run, FL);
    chk("single_after_sad", out_sad, 0);
    wait_idle();
    chk("single_word", {4'h0, last_word}, 32'h0A000135);

    // Back-to-back frames.
    fork
      measure_run("b2b_len", 3 * FL);
      begin
        push(28'h0000001, w);
        push(28'hFFFFFFF, w);
        push(28'h5555555, w);
      end
    join
    wait_idle();
    chk("b2b_last", {4'h0, last_word}, 32'h05555555);

    // Table of boundary data patterns.
    for (int unsigned i = 0; i < 6; i++) begin
      push(tbl[i].data, w);
      wait_idle();
      chk("tbl_word", {4'h0, last_word}, {4'h0, tbl[i].data});
`ifdef SAD_SERIAL_PARITY_EN
      chk("tbl_parity", last_par, tbl[i].par);
`endif
    end

    // Backpressure with res_valid held across 8 words.
    f0 = frames;
    for (int unsigned i = 1; i <= 8; i++) begin
      push(DW'(i), w);
      if (i == 5) chk("bp_full_ready", res_ready, 0);
      if (i == 6) chk("bp_wait6", w, FL - 3);
      if (i == 7) chk("bp_wait7", w, FL - 1);
    end
    wait_idle();
    chk("bp_frames", frames - f0, 8);
    chk("bp_last", {4'h0, last_word}, 32'h8);

    // Reset at bit 10 of a frame with two words queued.
    f0 = frames;
    push(28'h1234567, w);
    push(28'h0000002, w);
    push(28'h0000003, w);
    repeat (9) tick();
    chk("mid_bit10_valid", out_valid, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_sad", out_sad, 0);
    chk("mid_rst_ready", res_ready, 0);
    rst = 1'b0;
    n = 0;
    repeat (60) begin
      tick();
      if (out_valid) n++;
    end
    chk("mid_rst_quiet", n, 0);
    chk("mid_rst_frames", frames - f0, 0);
    push(28'h0000ABC, w);
    wait_idle();
    chk("post_rst_word", {4'h0, last_word}, 32'h00000ABC);

    // Push lands on the same edge that pops the queued word.
    push(28'h1111111, w);
    push(28'h2222222, w);
    run = 1;
    for (int unsigned t = 1; t < 400; t++) begin
      if (t == FL) begin
        chk("sim_ready", res_ready, 1);
        res_valid = 1'b1;
        res_data  = 28'h3333333;
      end
      tick();
      res_valid = 1'b0;
      if (!out_valid) break;
      run++;
    end
    chk("sim_contig", run, 3 * FL);
    wait_idle();
    chk("sim_last", {4'h0, last_word}, 32'h03333333);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
